// File: rtl/apf_video_encoder.sv
// apf_video_encoder: last video stage before the Pocket APF video bus.
// Turns level HS/VS into one-cycle pulses, holds HS off for a minimum gap
// after VS, blanks RGB outside DE, inserts the end-of-line scaler-slot word
// and measures the active width/height of each frame.
module apf_video_encoder #(
  parameter int unsigned VS_HS_GAP = 3,
  parameter int unsigned CNT_W     = 12
) (
  input  logic             clk_vid,
  input  logic             reset_n,
  input  logic [23:0]      scnl_rgb,
  input  logic             scnl_hs,
  input  logic             scnl_vs,
  input  logic             scnl_de,
  input  logic [2:0]       scaler_slot,
  output logic [23:0]      vid_rgb,
  output logic             vid_hs,
  output logic             vid_vs,
  output logic             vid_de,
  output logic [CNT_W-1:0] meas_width,
  output logic [CNT_W-1:0] meas_height,
  output logic             meas_valid
);

  localparam int unsigned RGB_W  = 24;
  localparam int unsigned SLOT_W = 3;
  localparam int unsigned GAP_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    HS_IDLE,
    HS_PENDING
  } hs_state_t;

  logic [RGB_W-1:0]  rgb_d1;
  logic [SLOT_W-1:0] slot_d1;
  logic [SLOT_W-1:0] slot_q;
  logic              hs_d1, hs_d2;
  logic              vs_d1, vs_d2;
  logic              de_d1, de_d2;

  logic [GAP_W-1:0]  gap_cnt;
  hs_state_t         hs_state;

  logic [CNT_W-1:0]  pix_cnt;
  logic [CNT_W-1:0]  line_cnt;
  logic [CNT_W-1:0]  line_w;

  logic              vs_rise_c;
  logic              hs_rise_c;
  logic              de_fall_c;
  logic [CNT_W-1:0]  line_inc_c;

  // Edge detection on the two-stage input pipeline.
  assign vs_rise_c  = vs_d1 & ~vs_d2;
  assign hs_rise_c  = hs_d1 & ~hs_d2;
  assign de_fall_c  = ~de_d1 & de_d2;
  assign line_inc_c = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + CNT_W'(1);

  // Input capture: d1 feeds the datapath, d2 only serves edge detection.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      rgb_d1  <= '0;
      slot_d1 <= '0;
      hs_d1   <= 1'b0;
      hs_d2   <= 1'b0;
      vs_d1   <= 1'b0;
      vs_d2   <= 1'b0;
      de_d1   <= 1'b0;
      de_d2   <= 1'b0;
    end else begin
      rgb_d1  <= scnl_rgb;
      slot_d1 <= scaler_slot;
      hs_d1   <= scnl_hs;
      hs_d2   <= hs_d1;
      vs_d1   <= scnl_vs;
      vs_d2   <= vs_d1;
      de_d1   <= scnl_de;
      de_d2   <= de_d1;
    end
  end

  // Sync pulse generation: VS pulse, VS-to-HS gap counter and HS deferral FSM.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      vid_vs   <= 1'b0;
      vid_hs   <= 1'b0;
      gap_cnt  <= '0;
      hs_state <= HS_IDLE;
    end else begin
      vid_vs <= vs_rise_c;
      vid_hs <= 1'b0;
      if (vs_rise_c) begin
        gap_cnt <= GAP_W'(VS_HS_GAP);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
      case (hs_state)
        HS_IDLE: begin
          if (hs_rise_c) begin
            if ((gap_cnt == '0) && !vs_rise_c) begin
              vid_hs <= 1'b1;
            end else begin
              hs_state <= HS_PENDING;
            end
          end
        end
        HS_PENDING: begin
          // Fire on the edge where the counter reaches zero; a new VS restarts the wait.
          if (!vs_rise_c && (gap_cnt <= GAP_W'(1))) begin
            vid_hs   <= 1'b1;
            hs_state <= HS_IDLE;
          end
        end
        default: hs_state <= HS_IDLE;
      endcase
    end
  end

  // Pixel output: active RGB, end-of-line slot word, otherwise black.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      vid_rgb <= '0;
      vid_de  <= 1'b0;
      slot_q  <= '0;
    end else begin
      vid_de <= de_d1;
      if (de_d1) begin
        vid_rgb <= rgb_d1;
      end else if (de_fall_c) begin
        vid_rgb <= {(RGB_W - SLOT_W)'(0), slot_q};
      end else begin
        vid_rgb <= '0;
      end
      if (vs_rise_c) begin
        slot_q <= slot_d1;
      end
    end
  end

  // Frame measurement: saturating pixel/line counters latched at each VS.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt     <= '0;
      line_cnt    <= '0;
      line_w      <= '0;
      meas_width  <= '0;
      meas_height <= '0;
      meas_valid  <= 1'b0;
    end else begin
      if (de_d1 && (pix_cnt != CNT_MAX)) begin
        pix_cnt <= pix_cnt + CNT_W'(1);
      end
      if (de_fall_c) begin
        line_w   <= pix_cnt;
        pix_cnt  <= '0;
        line_cnt <= line_inc_c;
      end
      if (vs_rise_c) begin
        // A line ending in the VS cycle still belongs to the closing frame.
        meas_width  <= de_fall_c ? pix_cnt : line_w;
        meas_height <= de_fall_c ? line_inc_c : line_cnt;
        line_cnt    <= '0;
        meas_valid  <= 1'b1;
      end
    end
  end

endmodule
